// File: rtl/bitfusion_pkg.sv
// ---------------------------------------------------------------------------
// bitfusion_pkg
// Shared definitions for the bitfusion dot-product sequencer:
//   - state_t       : job sequencer states
//   - W1/W2/W4      : the only operand precisions the fused multiplier accepts
//   - PSUM_W        : width of the multiplier's partial-product output
//   - psum_extend   : sign/zero extension of a psum to 32 bits
//   - width_ok      : legality check of one precision/sign pair
//   - width_mask    : operand mask keeping only the meaningful low bits
// ---------------------------------------------------------------------------
package bitfusion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] W1 = 3'd1;
    localparam logic [2:0] W2 = 3'd2;
    localparam logic [2:0] W4 = 3'd4;

    localparam int PSUM_W = 8;

    // Extends a psum to 32 bits; the caller truncates to its accumulator
    // width, so accumulators wider than 32 bits are not supported.
    function automatic logic [31:0] psum_extend(input logic [PSUM_W-1:0] psum,
                                                input logic              is_signed);
        logic [31:0] ext;
        if (is_signed)
            ext = {{(32-PSUM_W){psum[PSUM_W-1]}}, psum};
        else
            ext = {{(32-PSUM_W){1'b0}}, psum};
        return ext;
    endfunction

    // A 1-bit operand has no room for a sign bit, so signed width 1 is illegal.
    function automatic logic width_ok(input logic [2:0] width,
                                      input logic       is_signed);
        return (width == W2) || (width == W4) || ((width == W1) && !is_signed);
    endfunction

    function automatic logic [3:0] width_mask(input logic [2:0] width);
        logic [3:0] mask;
        case (width)
            W1:      mask = 4'b0001;
            W2:      mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bitfusion_lat_pipe.sv
// ---------------------------------------------------------------------------
// bitfusion_lat_pipe
// DEPTH-deep shift register of issue-valid tokens. A token entered with an
// operand pair leaves exactly DEPTH cycles later, which is when the matching
// psum is present on the multiplier output.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset, empties the pipe
//   i_valid - token inserted this cycle (operand handshake)
//   o_valid - token leaving the pipe (psum ready to retire)
// ---------------------------------------------------------------------------
module bitfusion_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_tok;

    // Stage 0 takes the new token, each later stage takes its predecessor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok <= '0;
        end else begin
            r_tok[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_tok[i] <= r_tok[i-1];
            end
        end
    end

    assign o_valid = r_tok[DEPTH-1];

endmodule

// File: rtl/bitfusion_dot_seq.sv
// ---------------------------------------------------------------------------
// bitfusion_dot_seq
// Job sequencer for one bitfusion_top fused multiplier. Accepts a job config,
// streams N operand pairs into the multiplier one per cycle, retires each
// psum MULT_LAT cycles after issue and accumulates a dot-product result.
// Ports:
//   clk, rst                  - clock / asynchronous active-high reset
//   cfg_*                     - job config handshake (precisions, signs, N)
//   op_*                      - operand pair stream handshake
//   mul_*                     - drive / observe the fused multiplier
//   res_valid/ready/data/err  - result handshake, res_err flags a rejected job
//   busy                      - a job is in progress or its result is pending
// ---------------------------------------------------------------------------
module bitfusion_dot_seq import bitfusion_pkg::*; #(
    parameter int LEN_W    = 8,
    parameter int ACC_W    = 16,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_in_width,
    input  logic [2:0]        cfg_weight_width,
    input  logic              cfg_s_in,
    input  logic              cfg_s_weight,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_in,
    input  logic [3:0]        op_weight,
    output logic [3:0]        mul_in,
    output logic [3:0]        mul_weight,
    output logic [2:0]        mul_in_width,
    output logic [2:0]        mul_weight_width,
    output logic              mul_s_in,
    output logic              mul_s_weight,
    input  logic [PSUM_W-1:0] mul_psum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_err,
    output logic              busy
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic [LEN_W-1:0]   r_retired;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_resData;
    logic               r_resErr;
    logic [3:0]         r_mulIn;
    logic [3:0]         r_mulWeight;
    logic [2:0]         r_mulInWidth;
    logic [2:0]         r_mulWeightWidth;
    logic               r_mulSIn;
    logic               r_mulSWeight;

    logic               w_cfgLegal;
    logic               w_jobStart;
    logic               w_opFire;
    logic               w_tokOut;
    logic [ACC_W-1:0]   w_psumExt;

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign res_valid = (r_state == DONE);
    assign op_ready  = (r_state == RUN) && (r_issued < r_len);

    assign w_cfgLegal = width_ok(cfg_in_width, cfg_s_in) &&
                        width_ok(cfg_weight_width, cfg_s_weight);
    // A legal non-empty job clears the accumulation state as it enters RUN.
    assign w_jobStart = cfg_valid && cfg_ready && w_cfgLegal && (cfg_len != '0);
    assign w_opFire   = op_valid && op_ready;

    // The psum is interpreted as signed whenever either operand is signed.
    assign w_psumExt = ACC_W'(psum_extend(mul_psum, r_mulSIn | r_mulSWeight));

    bitfusion_lat_pipe #(
        .DEPTH   (MULT_LAT)
    ) u_latPipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_opFire),
        .o_valid (w_tokOut)
    );

    // Job FSM together with everything it registers: latched config that
    // drives the multiplier, issued operands, issue count and the result.
    // Operands are masked to the configured width so garbage upper bits never
    // reach the multiplier; during bubbles the operand registers simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_len            <= '0;
            r_issued         <= '0;
            r_resData        <= '0;
            r_resErr         <= 1'b0;
            r_mulIn          <= '0;
            r_mulWeight      <= '0;
            r_mulInWidth     <= W4;
            r_mulWeightWidth <= W4;
            r_mulSIn         <= 1'b0;
            r_mulSWeight     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (!w_cfgLegal) begin
                            r_state   <= DONE;
                            r_resErr  <= 1'b1;
                            r_resData <= '0;
                        end else begin
                            r_mulInWidth     <= cfg_in_width;
                            r_mulWeightWidth <= cfg_weight_width;
                            r_mulSIn         <= cfg_s_in;
                            r_mulSWeight     <= cfg_s_weight;
                            r_len            <= cfg_len;
                            r_issued         <= '0;
                            if (cfg_len == '0) begin
                                r_state   <= DONE;
                                r_resErr  <= 1'b0;
                                r_resData <= '0;
                            end else begin
                                r_state <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    if (w_opFire) begin
                        r_mulIn     <= op_in & width_mask(r_mulInWidth);
                        r_mulWeight <= op_weight & width_mask(r_mulWeightWidth);
                        r_issued    <= r_issued + 1'b1;
                    end
                    // Uses the registered count, so the move to DRAIN lands
                    // one cycle after the Nth handshake.
                    if (r_issued == r_len) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_retired == r_len) begin
                        r_state   <= DONE;
                        r_resData <= r_acc;
                        r_resErr  <= 1'b0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Retire path: runs independently of issue, so a handshake and a retire
    // in the same cycle are both honoured. The sum wraps modulo 2^ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_retired <= '0;
        end else if (w_jobStart) begin
            r_acc     <= '0;
            r_retired <= '0;
        end else if (w_tokOut) begin
            r_acc     <= r_acc + w_psumExt;
            r_retired <= r_retired + 1'b1;
        end
    end

    assign mul_in           = r_mulIn;
    assign mul_weight       = r_mulWeight;
    assign mul_in_width     = r_mulInWidth;
    assign mul_weight_width = r_mulWeightWidth;
    assign mul_s_in         = r_mulSIn;
    assign mul_s_weight     = r_mulSWeight;
    assign res_data         = r_resData;
    assign res_err          = r_resErr;

endmodule

// File: doc/bitfusion_dot_seq.md
Name: bitfusion_dot_seq

Overview:
- Job sequencer for one bitfusion_top fused multiplier. It accepts a dot-product job config, then streams N operand pairs into the multiplier at one pair per cycle. It aligns each pair with its psum after the multiplier's fixed latency, accumulates the psums, and returns a single dot-product result.
- Sits between the PE-array scheduler (config and operand streams) and bitfusion_top. It is the only driver of the multiplier's width and sign inputs.

Parameters:
- LEN_W, 8, width of the job length (max N = 2^LEN_W-1)
- ACC_W, 16, accumulator/result width
- MULT_LAT, 2, cycles from multiplier input change to a valid psum (bitfusion_top settles within 2 clk)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  job config offered
- cfg_ready  out  1  high only in IDLE
- cfg_in_width  in  3  input precision: 1, 2 or 4
- cfg_weight_width  in  3  weight precision: 1, 2 or 4
- cfg_s_in  in  1  input is signed
- cfg_s_weight  in  1  weight is signed
- cfg_len  in  LEN_W  number of operand pairs N
- op_valid  in  1  operand pair offered
- op_ready  out  1  high in RUN while issued count < N
- op_in  in  4  input operand; low cfg_in_width bits meaningful
- op_weight  in  4  weight operand; low cfg_weight_width bits meaningful
- mul_in  out  4  to bitfusion_top .in
- mul_weight  out  4  to .weight
- mul_in_width  out  3  to .in_width
- mul_weight_width  out  3  to .weight_width
- mul_s_in  out  1  to .s_in
- mul_s_weight  out  1  to .s_weight
- mul_psum  in  8  from .psum
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  ACC_W  dot-product result
- res_err  out  1  job rejected (illegal config)
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, all mul_* 0, mul_in_width 4, mul_weight_width 4, res_valid 0, res_data 0, res_err 0, issued and retired counts 0, accumulator 0.
- Reset mid-job aborts immediately. No result is emitted for the aborted job.
- IDLE: on cfg_valid && cfg_ready, latch the config.
  - Width not in {1,2,4}, or width 1 with its sign flag set: go to DONE with res_err=1, res_data=0, no operands consumed.
  - cfg_len=0: go to DONE with res_err=0, res_data=0.
  - Otherwise: go to RUN and clear the accumulator.
- RUN: on op_valid && op_ready, register the pair onto mul_in/mul_weight.
  - Bits at and above the configured width are forced to 0.
  - mul_* width and sign outputs hold the latched config for the whole job.
  - Record an issue-valid token in a MULT_LAT-deep shift register.
  - When issued == N, go to DRAIN. If the Nth handshake occurs this cycle, the transition happens the next cycle.
- Operand bubbles (op_valid low): no token is inserted; mul_in/mul_weight hold their value.
- Retire: when a token exits the shift register, sample mul_psum and extend it to ACC_W.
  - Sign-extend from bit 7 if s_in|s_weight; otherwise zero-extend.
  - Add to the accumulator modulo 2^ACC_W (wrap, no saturation). Increment retired.
- DRAIN: stay until retired == N, then go to DONE. res_data = accumulator including the final psum.
- DONE: res_valid=1 and res_data/res_err stable until res_ready.
  - On the handshake go to IDLE and drop res_valid the next cycle.
  - cfg_ready is 0 in DONE, so a new job cannot overlap an unconsumed result.
- Throughput: one pair per cycle with no bubbles. Latency from the last operand handshake to res_valid is MULT_LAT+1 cycles.
- Simultaneous op handshake and retire in one cycle are both handled; counts are independent.

Decomposition:
- Shared package bitfusion_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - legal-width constants W1=1, W2=2, W4=4
  - PSUM_W=8
  - function psum_extend(psum, is_signed)
- One sub-module: bitfusion_lat_pipe, a MULT_LAT-deep valid-token shift register, cleared asynchronously by rst.

Test Plan:
- Unsigned 4x4, N=3, pairs (15,15),(3,5),(0,9) -> res_data=240, res_err=0; res_valid exactly MULT_LAT+1 cycles after the 3rd handshake.
- Signed 4x4, N=2, pairs (-8,7),(-1,-1) -> psums 0xC8 and 0x01; res_data=16'hFFC9 (-55).
- Mixed signed in_width=2, weight_width=4, N=2, op_in=4'b1110 (upper bits garbage, -2 in 2 bits), op_weight=7, then (1,-8) -> mul_in observed as 4'b0010; res_data=-22.
- Illegal config in_width=3 -> DONE with res_err=1, res_data=0, op_ready never asserted. Also cfg_len=0 -> res_data=0, res_err=0.
- Backpressure: op_valid toggling every other cycle, and res_ready held low 5 cycles -> result still correct; res_valid and res_data stable while stalled; cfg_ready=0 until the handshake.
- Reset asserted in RUN after 2 of 4 pairs -> all outputs return to reset values the same cycle. A subsequent job N=1 (2,3) returns 6, with no leakage from the aborted job.
